// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
// Parametrised-width ALU for the MIPS EX stage. Add, sub, logic, compare and
// shift results are combinational. An iterative unsigned multiply/divide
// engine writes the HI/LO registers over WIDTH cycles, using a
// start/busy/done handshake. Control stalls the PC while busy is high.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   src1         operand A; for shifts, src1[SHW-1:0] is the shift amount
//   src2         operand B; for shifts, the value being shifted
//   alu_control  4-bit operation select
//   start        launches MULTU/DIVU when the engine is idle
//   alu_result   combinational result (lo for the MULTU/DIVU codes)
//   zero         alu_result == 0
//   hi, lo       registered product halves, or remainder/quotient
//   busy         iterative operation in progress
//   done         one-cycle pulse when hi/lo have just been updated
//   div_by_zero  set with done when a DIVU had a zero divisor
// -----------------------------------------------------------------------------
module alu_muldiv #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       alu_control,
   input  logic             start,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLTU  = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SLT   = 4'b1010;
   localparam logic [3:0] OP_SRA   = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SHW-1:0]         cnt_q, cnt_d;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]       opb_q, opb_d;      // multiplicand or divisor
   logic [WIDTH-1:0]       hi_q, hi_d;
   logic [WIDTH-1:0]       lo_q, lo_d;
   logic                   done_q, done_d;
   logic                   dbz_q, dbz_d;

   logic [WIDTH-1:0]       alu_result_s;
   logic [SHW-1:0]         shamt_s;
   logic [WIDTH:0]         mul_sum_s;
   logic [2*WIDTH-1:0]     mul_next_s;
   logic [WIDTH:0]         div_trial_s;
   logic [WIDTH:0]         div_diff_s;
   logic [2*WIDTH-1:0]     div_next_s;
   logic                   launch_s;

   assign shamt_s = src1[SHW-1:0];

   // Single-cycle ALU result selection
   always_comb begin
      alu_result_s = {WIDTH{1'b0}};
      case (alu_control)
         OP_ADD:   alu_result_s = src1 + src2;
         OP_SUB:   alu_result_s = src1 - src2;
         OP_AND:   alu_result_s = src1 & src2;
         OP_OR:    alu_result_s = src1 | src2;
         OP_XOR:   alu_result_s = src1 ^ src2;
         OP_NOR:   alu_result_s = ~(src1 | src2);
         OP_SLTU:  alu_result_s = {{(WIDTH-1){1'b0}}, (src1 < src2)};
         OP_SLT:   alu_result_s = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
         OP_SLL:   alu_result_s = src2 << shamt_s;
         OP_SRL:   alu_result_s = src2 >> shamt_s;
         OP_SRA:   alu_result_s = $unsigned($signed(src2) >>> shamt_s);
         OP_MULTU: alu_result_s = lo_q;
         OP_DIVU:  alu_result_s = lo_q;
         default:  alu_result_s = {WIDTH{1'b0}};
      endcase
   end

   assign alu_result = alu_result_s;
   assign zero       = (alu_result_s == {WIDTH{1'b0}});

   // One shift-add multiply step and one restoring divide step
   always_comb begin
      // Multiply: add the multiplicand when the current multiplier bit is
      // set, then shift the whole accumulator right, keeping the carry.
      mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
      // Divide: shift the next dividend bit into the remainder, then try to
      // subtract the divisor. A borrow means restore and shift in a 0.
      div_trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff_s  = div_trial_s - {1'b0, opb_q};
      if (!div_diff_s[WIDTH]) begin
         div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   assign launch_s = start && ((alu_control == OP_MULTU) || (alu_control == OP_DIVU));

   // Multiply/divide control: next state, iteration and result update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (launch_s) begin
               acc_d   = {{WIDTH{1'b0}}, src1};
               opb_d   = src2;
               cnt_d   = {SHW{1'b0}};
               dbz_d   = 1'b0;
               state_d = (alu_control == OP_MULTU) ? ST_MUL : ST_DIV;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            acc_d = mul_next_s;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == CNT_LAST) begin
               hi_d    = mul_next_s[2*WIDTH-1:WIDTH];
               lo_d    = mul_next_s[WIDTH-1:0];
               done_d  = 1'b1;
               cnt_d   = {SHW{1'b0}};
               state_d = ST_IDLE;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DIV: begin
            if (opb_q == {WIDTH{1'b0}}) begin
               // The dividend is still untouched in the low half of acc_q.
               lo_d    = {WIDTH{1'b1}};
               hi_d    = acc_q[WIDTH-1:0];
               dbz_d   = 1'b1;
               done_d  = 1'b1;
               cnt_d   = {SHW{1'b0}};
               state_d = ST_IDLE;
            end else begin
               acc_d = div_next_s;
               cnt_d = cnt_q + SHW'(1);
               if (cnt_q == CNT_LAST) begin
                  hi_d    = div_next_s[2*WIDTH-1:WIDTH];
                  lo_d    = div_next_s[WIDTH-1:0];
                  done_d  = 1'b1;
                  cnt_d   = {SHW{1'b0}};
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DIV;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {SHW{1'b0}};
         end
      endcase
   end

   // State and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {SHW{1'b0}};
         acc_q   <= {(2*WIDTH){1'b0}};
         opb_q   <= {WIDTH{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

   localparam logic [3:0] C_ADD = 4'b0010, C_SUB = 4'b0110, C_AND = 4'b0000,
                          C_OR  = 4'b0001, C_XOR = 4'b0011, C_NOR = 4'b1100,
                          C_SLTU = 4'b0111, C_SLT = 4'b1010, C_SLL = 4'b1000,
                          C_SRL = 4'b1001, C_SRA = 4'b1011, C_MULTU = 4'b1101,
                          C_DIVU = 4'b1110;

   logic        clk;
   logic        reset;
   logic [31:0] a32, b32, res32, hi32, lo32;
   logic [3:0]  ctl32;
   logic        st32, zero32, busy32, done32, dbz32;
   logic [7:0]  a8, b8, res8, hi8, lo8;
   logic [3:0]  ctl8;
   logic        st8, zero8, busy8, done8, dbz8;

   int n_vec;
   int n_mis;

   alu_muldiv #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .src1(a32), .src2(b32), .alu_control(ctl32),
      .start(st32), .alu_result(res32), .zero(zero32), .hi(hi32), .lo(lo32),
      .busy(busy32), .done(done32), .div_by_zero(dbz32));

   alu_muldiv #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .src1(a8), .src2(b8), .alu_control(ctl8),
      .start(st8), .alu_result(res8), .zero(zero8), .hi(hi8), .lo(lo8),
      .busy(busy8), .done(done8), .div_by_zero(dbz8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Launch one MULTU/DIVU on the 32-bit unit and check the whole handshake.
   // glitch_at > 0 pulses start (with a DIVU code) at that cycle of the run.
   task automatic run32(input string tag, input logic [3:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz, input int exp_cyc, input int glitch_at);
      logic [31:0] h0, l0;
      int n;
      bit stable;
      @(negedge clk);
      h0 = hi32; l0 = lo32;
      ctl32 = ctrl; a32 = a; b32 = b; st32 = 1'b1;
      @(negedge clk);
      st32 = 1'b0; a32 = ~a; b32 = ~b;
      #1;
      check({tag, " busy_after_launch"}, 64'(busy32), 64'd1);
      n = 0;
      stable = 1'b1;
      while (!done32 && n < 200) begin
         if (hi32 !== h0 || lo32 !== l0) stable = 1'b0;
         if (glitch_at > 0 && n == glitch_at) begin
            st32 = 1'b1; ctl32 = C_DIVU; a32 = 32'd3; b32 = 32'd0;
         end else begin
            st32 = 1'b0; ctl32 = ctrl;
         end
         @(posedge clk);
         n++;
         @(negedge clk);
         #1;
      end
      check({tag, " cycles"}, 64'(n), 64'(exp_cyc));
      check({tag, " hi"}, 64'(hi32), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo32), 64'(exp_lo));
      check({tag, " div_by_zero"}, 64'(dbz32), 64'(exp_dbz));
      check({tag, " busy_at_done"}, 64'(busy32), 64'd0);
      check({tag, " alu_result_is_lo"}, 64'(res32), 64'(exp_lo));
      check({tag, " hilo_stable_while_busy"}, 64'(stable), 64'd1);
      @(negedge clk);
      #1;
      check({tag, " done_one_cycle"}, 64'(done32), 64'd0);
      check({tag, " dbz_holds"}, 64'(dbz32), 64'(exp_dbz));
   endtask

   initial begin
      int n;
      bit saw_done;
      n_vec = 0;
      n_mis = 0;
      reset = 1'b1;
      a32 = 32'd0; b32 = 32'd0; ctl32 = 4'b0000; st32 = 1'b0;
      a8 = 8'd0; b8 = 8'd0; ctl8 = 4'b0000; st8 = 1'b0;

      vecs[0]  = '{C_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      vecs[1]  = '{C_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
      vecs[2]  = '{C_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
      vecs[3]  = '{C_OR,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF};
      vecs[4]  = '{C_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
      vecs[5]  = '{C_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF};
      vecs[6]  = '{C_NOR,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000};
      vecs[7]  = '{C_SLT,  32'h80000000, 32'h00000001, 32'h00000001};
      vecs[8]  = '{C_SLTU, 32'h80000000, 32'h00000001, 32'h00000000};
      vecs[9]  = '{C_SLT,  32'h00000001, 32'h80000000, 32'h00000000};
      vecs[10] = '{C_SLTU, 32'h00000001, 32'h80000000, 32'h00000001};
      vecs[11] = '{C_SRA,  32'h00000004, 32'h80000000, 32'hF8000000};
      vecs[12] = '{C_SRL,  32'h00000004, 32'h80000000, 32'h08000000};
      vecs[13] = '{C_SLL,  32'h0000001F, 32'h00000001, 32'h80000000};
      vecs[14] = '{C_SRA,  32'h0000001F, 32'h7FFFFFFF, 32'h00000000};
      vecs[15] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000};
      vecs[16] = '{C_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst hi32", 64'(hi32), 64'd0);
      check("rst lo32", 64'(lo32), 64'd0);
      check("rst busy32", 64'(busy32), 64'd0);
      check("rst done32", 64'(done32), 64'd0);
      check("rst dbz32", 64'(dbz32), 64'd0);
      check("rst busy8", 64'(busy8), 64'd0);
      reset = 1'b0;

      // Combinational vectors
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         ctl32 = vecs[i].ctrl; a32 = vecs[i].a; b32 = vecs[i].b;
         #2;
         check($sformatf("vec%0d result", i), 64'(res32), 64'(vecs[i].res));
         check($sformatf("vec%0d zero", i), 64'(zero32),
               (vecs[i].res == 32'd0) ? 64'd1 : 64'd0);
      end

      // Multi-cycle operations on the 32-bit unit
      run32("multu_max", C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32, 0);
      run32("multu_pow", C_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 32, 0);
      run32("divu_100_7", C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32, 0);
      run32("divu_by0", C_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1, 1, 0);
      run32("divu_big", C_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 32, 0);
      run32("divu_small", C_DIVU, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 32, 0);
      run32("multu_glitch", C_MULTU, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32, 5);

      // Reset in the middle of a divide: cleared at once, no done pulse
      @(negedge clk);
      ctl32 = C_DIVU; a32 = 32'd100; b32 = 32'd7; st32 = 1'b1;
      @(negedge clk);
      st32 = 1'b0;
      for (int i = 0; i < 10; i++) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst busy", 64'(busy32), 64'd0);
      check("midrst hi", 64'(hi32), 64'd0);
      check("midrst lo", 64'(lo32), 64'd0);
      check("midrst done", 64'(done32), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done32 || busy32) saw_done = 1'b1;
      end
      check("midrst no_done_or_busy", 64'(saw_done), 64'd0);

      // WIDTH=8: MULTU then a back-to-back DIVU launched in the done cycle
      @(negedge clk);
      ctl8 = C_MULTU; a8 = 8'hFF; b8 = 8'h02; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      #1;
      n = 0;
      while (!done8 && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         #1;
      end
      check("w8 multu cycles", 64'(n), 64'd8);
      check("w8 multu hi", 64'(hi8), 64'h01);
      check("w8 multu lo", 64'(lo8), 64'hFE);
      ctl8 = C_DIVU; a8 = 8'hC8; b8 = 8'h0D; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0; a8 = 8'h01; b8 = 8'h01;
      #1;
      check("w8 b2b done_dropped", 64'(done8), 64'd0);
      check("w8 b2b busy", 64'(busy8), 64'd1);
      n = 0;
      while (!done8 && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         #1;
      end
      check("w8 divu cycles", 64'(n), 64'd8);
      check("w8 divu lo", 64'(lo8), 64'h0F);
      check("w8 divu hi", 64'(hi8), 64'h05);
      check("w8 divu dbz", 64'(dbz8), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
